// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer: pushes PC and P, fetches the vector and reloads the PC.
// Optional INT_SEQ_VECTORED_EN gives each IRQ source its own vector at IRQ_VEC_BASE + 2*index.
module int_seq #(
    parameter int unsigned N_IRQ        = 4,
    parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             nmi_n,
    input  logic [N_IRQ-1:0] irq_n,
    input  logic             i_flag,
    input  logic [15:0]      pc,
    input  logic [7:0]       p,
    input  logic [7:0]       sp,
    input  logic [7:0]       d,
    output logic             busy,
    output logic [15:0]      a,
    output logic [7:0]       wdata,
    output logic             rw,
    output logic             sp_dec,
    output logic             pc_load,
    output logic             set_i,
    output logic [15:0]      pc_new
);

    typedef enum logic [3:0] {
        StRstL, StRstH, StIdle, StPushH, StPushL, StPushP, StFetchL, StFetchH, StDone
    } state_e;

    state_e      state_q, state_d;
    logic        nmi_prev_q, nmi_pend_q, nmi_pend_d, is_nmi_q, is_nmi_d;
    logic [15:0] pc_q;
    logic [7:0]  p_q, sp_q, lo_q, hi_q;
    logic        nmi_edge, nmi_any, irq_take, take;
    logic [15:0] irq_vec, vec;
    logic        unused_p;

    assign nmi_edge = nmi_prev_q & ~nmi_n;
    // A fresh edge counts in the same cycle so it can win or hijack immediately.
    assign nmi_any  = nmi_pend_q | nmi_edge;
    assign irq_take = ~(&irq_n) & ~i_flag;
    assign take     = sync & (nmi_any | irq_take);
    assign unused_p = ^p_q[5:4];

`ifdef INT_SEQ_VECTORED_EN
    logic [2:0] irq_idx, irq_idx_q;

    always_comb begin
        irq_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (!irq_n[i]) irq_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_idx_q <= '0;
        end else if (state_q == StIdle && take) begin
            irq_idx_q <= irq_idx;
        end
    end

    assign irq_vec = IRQ_VEC_BASE + {12'h000, irq_idx_q, 1'b0};
`else
    logic unused_vec_base;
    assign unused_vec_base = ^IRQ_VEC_BASE;
    assign irq_vec         = 16'hFFFE;
`endif

    assign vec = is_nmi_q ? 16'hFFFA : irq_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRstL;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            is_nmi_q   <= 1'b0;
            pc_q       <= '0;
            p_q        <= '0;
            sp_q       <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            nmi_prev_q <= nmi_n;
            nmi_pend_q <= nmi_pend_d;
            is_nmi_q   <= is_nmi_d;
            if (state_q == StIdle && take) begin
                pc_q <= pc;
                p_q  <= p;
                sp_q <= sp;
            end
            if (state_q == StRstL || state_q == StFetchL) lo_q <= d;
            if (state_q == StRstH || state_q == StFetchH) hi_q <= d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nmi_pend_d = nmi_any;
        is_nmi_d   = is_nmi_q;
        unique case (state_q)
            StRstL:  state_d = StRstH;
            StRstH:  state_d = StDone;
            StIdle: begin
                if (take) begin
                    state_d  = StPushH;
                    is_nmi_d = nmi_any;
                end
            end
            StPushH: begin
                state_d  = StPushL;
                is_nmi_d = is_nmi_q | nmi_any;
            end
            StPushL: begin
                state_d  = StPushP;
                is_nmi_d = is_nmi_q | nmi_any;
            end
            StPushP: begin
                // Last chance for an NMI to take over; edges after this stay pending.
                state_d  = StFetchL;
                is_nmi_d = is_nmi_q | nmi_any;
                if (is_nmi_d) nmi_pend_d = 1'b0;
            end
            StFetchL: state_d = StFetchH;
            StFetchH: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = 1'b1;
        a       = 16'h0000;
        rw      = 1'b1;
        wdata   = 8'h00;
        sp_dec  = 1'b0;
        pc_load = 1'b0;
        set_i   = 1'b0;
        pc_new  = 16'h0000;
        unique case (state_q)
            StRstL:  a = 16'hFFFC;
            StRstH:  a = 16'hFFFD;
            StIdle:  busy = 1'b0;
            StPushH: begin
                rw     = 1'b0;
                sp_dec = 1'b1;
                a      = {8'h01, sp_q};
                wdata  = pc_q[15:8];
            end
            StPushL: begin
                rw     = 1'b0;
                sp_dec = 1'b1;
                a      = {8'h01, 8'(sp_q - 8'd1)};
                wdata  = pc_q[7:0];
            end
            StPushP: begin
                rw     = 1'b0;
                sp_dec = 1'b1;
                a      = {8'h01, 8'(sp_q - 8'd2)};
                wdata  = {p_q[7:6], 2'b10, p_q[3:0]};
            end
            StFetchL: a = vec;
            StFetchH: a = vec + 16'd1;
            StDone: begin
                pc_load = 1'b1;
                set_i   = 1'b1;
                pc_new  = {hi_q, lo_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq: row table of stimulus/expected outputs fed through a queue,
// plus a hand-written asynchronous abort check.
module tb_int_seq;

    logic        clk = 1'b0;
    logic        rst_n, sync, nmi_n, i_flag;
    logic [3:0]  irq_n;
    logic [15:0] pc;
    logic [7:0]  p, sp, d;
    logic        busy, rw, sp_dec, pc_load, set_i;
    logic [15:0] a, pc_new;
    logic [7:0]  wdata;

    int checks   = 0;
    int failures = 0;

`ifdef INT_SEQ_VECTORED_EN
    localparam logic [15:0] Irq0V = 16'hFFE0;
    localparam logic [15:0] Irq1V = 16'hFFE2;
`else
    localparam logic [15:0] Irq0V = 16'hFFFE;
    localparam logic [15:0] Irq1V = 16'hFFFE;
`endif

    int_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync   (sync),
        .nmi_n  (nmi_n),
        .irq_n  (irq_n),
        .i_flag (i_flag),
        .pc     (pc),
        .p      (p),
        .sp     (sp),
        .d      (d),
        .busy   (busy),
        .a      (a),
        .wdata  (wdata),
        .rw     (rw),
        .sp_dec (sp_dec),
        .pc_load(pc_load),
        .set_i  (set_i),
        .pc_new (pc_new)
    );

    always #5 clk = ~clk;

    typedef enum {KIdle, KPush, KRead, KDone} kind_e;

    typedef struct {
        string       nm;
        logic        rst_n, sync, nmi_n, i_flag;
        logic [3:0]  irq_n;
        logic [15:0] pc;
        logic [7:0]  p, sp, d;
        logic        busy, rw, sp_dec, pc_load;
        logic [15:0] a, pc_new;
        logic [7:0]  wdata;
    } row_t;

    row_t vecs[$];
    row_t exp_q[$];

    logic        c_rst_n, c_sync, c_nmi_n, c_i_flag;
    logic [3:0]  c_irq_n;
    logic [15:0] c_pc;
    logic [7:0]  c_p, c_sp, c_d;

    // Row = inputs held for one cycle, plus the outputs expected after the next rising edge.
    task automatic add(input string nm, input kind_e k, input logic [15:0] av,
                       input logic [7:0] wv);
        row_t r;
        r.nm      = nm;
        r.rst_n   = c_rst_n;
        r.sync    = c_sync;
        r.nmi_n   = c_nmi_n;
        r.i_flag  = c_i_flag;
        r.irq_n   = c_irq_n;
        r.pc      = c_pc;
        r.p       = c_p;
        r.sp      = c_sp;
        r.d       = c_d;
        r.busy    = (k != KIdle);
        r.a       = (k == KPush || k == KRead) ? av : 16'h0000;
        r.rw      = (k != KPush);
        r.wdata   = (k == KPush) ? wv : 8'h00;
        r.sp_dec  = (k == KPush);
        r.pc_load = (k == KDone);
        r.pc_new  = (k == KDone) ? av : 16'h0000;
        vecs.push_back(r);
    endtask

    task automatic check_row(input row_t e);
        checks++;
        if (busy !== e.busy || a !== e.a || rw !== e.rw || wdata !== e.wdata ||
            sp_dec !== e.sp_dec || pc_load !== e.pc_load || set_i !== e.pc_load ||
            pc_new !== e.pc_new) begin
            failures++;
            $display("FAIL %s: got busy=%b a=%h rw=%b wdata=%h sp_dec=%b pc_load=%b set_i=%b pc_new=%h; want busy=%b a=%h rw=%b wdata=%h sp_dec=%b pc_load=%b set_i=%b pc_new=%h",
                     e.nm, busy, a, rw, wdata, sp_dec, pc_load, set_i, pc_new,
                     e.busy, e.a, e.rw, e.wdata, e.sp_dec, e.pc_load, e.pc_load, e.pc_new);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            sync   = vecs[i].sync;
            nmi_n  = vecs[i].nmi_n;
            i_flag = vecs[i].i_flag;
            irq_n  = vecs[i].irq_n;
            pc     = vecs[i].pc;
            p      = vecs[i].p;
            sp     = vecs[i].sp;
            d      = vecs[i].d;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            check_row(exp_q.pop_front());
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        c_rst_n = 0; c_sync = 0; c_nmi_n = 1; c_i_flag = 0; c_irq_n = 4'hF;
        c_pc = 16'h0000; c_p = 8'h00; c_sp = 8'hFF; c_d = 8'h00;
        rst_n = 0; sync = 0; nmi_n = 1; i_flag = 0; irq_n = 4'hF;
        pc = 0; p = 0; sp = 8'hFF; d = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset sequence
        add("rst_hold", KRead, 16'hFFFC, 8'h00);
        c_rst_n = 1; c_d = 8'h00;          add("rst_lo", KRead, 16'hFFFD, 8'h00);
        c_d = 8'hC0;                       add("rst_done", KDone, 16'hC000, 8'h00);
        c_d = 8'h00;                       add("rst_idle", KIdle, 16'h0, 8'h00);
        c_sync = 1;                        add("idle_no_src", KIdle, 16'h0, 8'h00);

        // Plain IRQ from source 0; inputs change after the take to prove capture
        c_pc = 16'h1234; c_p = 8'h81; c_sp = 8'hFD; c_irq_n = 4'b1110;
        add("irq_push_h", KPush, 16'h01FD, 8'h12);
        c_sync = 0; c_pc = 16'hDEAD; c_p = 8'h00; c_sp = 8'h00;
        add("irq_push_l", KPush, 16'h01FC, 8'h34);
        add("irq_push_p", KPush, 16'h01FB, 8'hA1);
        add("irq_fetch_l", KRead, Irq0V, 8'h00);
        c_d = 8'h78;                       add("irq_fetch_h", KRead, Irq0V + 16'd1, 8'h00);
        c_d = 8'h56;                       add("irq_done", KDone, 16'h5678, 8'h00);
        c_d = 8'h00;                       add("irq_idle", KIdle, 16'h0, 8'h00);

        // Masked IRQ
        c_i_flag = 1; c_sync = 1;          add("masked_1", KIdle, 16'h0, 8'h00);
        add("masked_2", KIdle, 16'h0, 8'h00);

        // NMI edge and IRQ 1 at the same sync: NMI first, IRQ 1 next
        c_i_flag = 0; c_nmi_n = 0; c_irq_n = 4'b1101;
        c_pc = 16'h2000; c_p = 8'h00; c_sp = 8'hFF;
        add("nmi_push_h", KPush, 16'h01FF, 8'h20);
        c_sync = 0;                        add("nmi_push_l", KPush, 16'h01FE, 8'h00);
        add("nmi_push_p", KPush, 16'h01FD, 8'h20);
        add("nmi_fetch_l", KRead, 16'hFFFA, 8'h00);
        c_d = 8'h11;                       add("nmi_fetch_h", KRead, 16'hFFFB, 8'h00);
        c_d = 8'h22;                       add("nmi_done", KDone, 16'h2211, 8'h00);
        c_d = 8'h00;                       add("nmi_idle", KIdle, 16'h0, 8'h00);
        c_sync = 1; c_pc = 16'h3000; c_p = 8'hC3; c_sp = 8'h80;
        add("irq1_push_h", KPush, 16'h0180, 8'h30);
        c_sync = 0;                        add("irq1_push_l", KPush, 16'h017F, 8'h00);
        add("irq1_push_p", KPush, 16'h017E, 8'hE3);
        add("irq1_fetch_l", KRead, Irq1V, 8'h00);
        c_d = 8'h44;                       add("irq1_fetch_h", KRead, Irq1V + 16'd1, 8'h00);
        c_d = 8'h33;                       add("irq1_done", KDone, 16'h3344, 8'h00);
        c_d = 8'h00; c_irq_n = 4'hF; c_nmi_n = 1;
        add("irq1_idle", KIdle, 16'h0, 8'h00);
        run_vecs();

        // Hijack during PUSH_L, then a late NMI during FETCH_H
        c_sync = 1; c_irq_n = 4'b1110; c_pc = 16'h4000; c_p = 8'h00; c_sp = 8'h40;
        add("hj_push_h", KPush, 16'h0140, 8'h40);
        c_sync = 0;                        add("hj_push_l", KPush, 16'h013F, 8'h00);
        c_nmi_n = 0;                       add("hj_push_p", KPush, 16'h013E, 8'h20);
        c_nmi_n = 1;                       add("hj_fetch_l", KRead, 16'hFFFA, 8'h00);
        c_d = 8'hBB;                       add("hj_fetch_h", KRead, 16'hFFFB, 8'h00);
        c_d = 8'hAA; c_nmi_n = 0;          add("hj_done", KDone, 16'hAABB, 8'h00);
        c_d = 8'h00; c_irq_n = 4'hF;       add("hj_idle", KIdle, 16'h0, 8'h00);
        c_sync = 1; c_pc = 16'h5000; c_sp = 8'h30;
        add("late_push_h", KPush, 16'h0130, 8'h50);
        c_sync = 0;                        add("late_push_l", KPush, 16'h012F, 8'h00);
        add("late_push_p", KPush, 16'h012E, 8'h20);
        add("late_fetch_l", KRead, 16'hFFFA, 8'h00);
        c_d = 8'h02;                       add("late_fetch_h", KRead, 16'hFFFB, 8'h00);
        c_d = 8'h01;                       add("late_done", KDone, 16'h0102, 8'h00);
        c_d = 8'h00;                       add("late_idle", KIdle, 16'h0, 8'h00);
        c_sync = 1;                        add("nmi_cleared", KIdle, 16'h0, 8'h00);

        // Stack pointer wrap
        c_irq_n = 4'b1110; c_sp = 8'h01; c_pc = 16'h6000; c_p = 8'h00;
        add("wrap_push_h", KPush, 16'h0101, 8'h60);
        c_sync = 0;                        add("wrap_push_l", KPush, 16'h0100, 8'h00);
        add("wrap_push_p", KPush, 16'h01FF, 8'h20);
        add("wrap_fetch_l", KRead, Irq0V, 8'h00);
        c_d = 8'hEF;                       add("wrap_fetch_h", KRead, Irq0V + 16'd1, 8'h00);
        c_d = 8'hBE;                       add("wrap_done", KDone, 16'hBEEF, 8'h00);
        c_d = 8'h00; c_irq_n = 4'hF;       add("wrap_idle", KIdle, 16'h0, 8'h00);

        // Reset abort, entered in PUSH_L
        c_sync = 1; c_irq_n = 4'b1110;     add("abort_push_h", KPush, 16'h0101, 8'h60);
        c_sync = 0; c_irq_n = 4'hF;        add("abort_push_l", KPush, 16'h0100, 8'h00);
        run_vecs();

        #2;
        rst_n = 0;
        #1;
        checks++;
        if (busy !== 1'b1 || rw !== 1'b1 || a !== 16'hFFFC || sp_dec !== 1'b0 ||
            wdata !== 8'h00 || pc_load !== 1'b0 || set_i !== 1'b0 || pc_new !== 16'h0000) begin
            failures++;
            $display("FAIL abort_now: got busy=%b rw=%b a=%h sp_dec=%b wdata=%h pc_load=%b set_i=%b pc_new=%h; want 1 1 fffc 0 00 0 0 0000",
                     busy, rw, a, sp_dec, wdata, pc_load, set_i, pc_new);
        end

        c_rst_n = 0;                       add("abort_rst_hold", KRead, 16'hFFFC, 8'h00);
        c_rst_n = 1; c_d = 8'h34;          add("abort_rst_lo", KRead, 16'hFFFD, 8'h00);
        c_d = 8'h12;                       add("abort_rst_done", KDone, 16'h1234, 8'h00);
        c_d = 8'h00;                       add("abort_rst_idle", KIdle, 16'h0, 8'h00);
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_seq.md
INT_SEQ -- requirements
Module: int_seq

Interface
REQ-001 SHALL have parameter N_IRQ, default 4: number of level-sensitive IRQ sources, legal range 1..8.
REQ-002 SHALL have parameter IRQ_VEC_BASE, default 16'hFFE0: base address of the per-source vector table.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port sync, input, 1 bit: core opcode-fetch cycle, used as the instruction boundary.
REQ-006 SHALL have port nmi_n, input, 1 bit: NMI, falling-edge sensitive.
REQ-007 SHALL have port irq_n, input, N_IRQ bits: active-low level IRQ sources; index 0 has highest priority.
REQ-008 SHALL have ports i_flag (input, 1 bit, IRQ mask), pc (input, 16 bits), p (input, 8 bits), sp (input, 8 bits) and d (input, 8 bits, read data).
REQ-009 SHALL have port busy, output, 1 bit: the block owns the bus and the core stalls.
REQ-010 SHALL have ports a (output, 16 bits, address), wdata (output, 8 bits) and rw (output, 1 bit; 1 = read, 0 = write).
REQ-011 SHALL have output pulses sp_dec, pc_load and set_i (1 bit each), plus pc_new (output, 16 bits).

Function
REQ-012 SHALL register nmi_n each cycle and set nmi_pend on previous=1, current=0; nmi_pend clears when the NMI vector fetch starts.
REQ-013 SHALL define irq_take as: any irq_n bit low and i_flag=0.
REQ-014 SHALL take an interrupt only when sync=1 and (nmi_pend or irq_take) in state IDLE; NMI wins, and a level IRQ stays pending.
REQ-015 SHALL, on take, capture pc, p and sp, plus the lowest asserted IRQ index.
REQ-016 SHALL sequence IDLE->PUSH_H->PUSH_L->PUSH_P->FETCH_L->FETCH_H->DONE->IDLE, one cycle per state; busy=1 outside IDLE.
REQ-017 PUSH_H/L/P SHALL drive rw=0, a=16'h0100|(sp_cap-k) for k=0,1,2 with 8-bit wrap (8'h00-1=8'hFF), and sp_dec=1.
REQ-018 PUSH_H/L/P SHALL write wdata = pc_cap[15:8], pc_cap[7:0], then {p_cap[7:6],1'b1,1'b0,p_cap[3:0]}.
REQ-019 FETCH_L SHALL drive rw=1, a=vec and register d as the low byte; FETCH_H SHALL drive a=vec+1 and register d as the high byte.
REQ-020 DONE SHALL pulse pc_load=1 and set_i=1 with pc_new={hi,lo} for exactly one cycle.
REQ-021 vec SHALL be 16'hFFFA for NMI, 16'hFFFE for IRQ (see REQ-030) and 16'hFFFC for reset.
REQ-022 An NMI edge arriving during IRQ PUSH_H..PUSH_P SHALL hijack the sequence: vec becomes 16'hFFFA at FETCH_L and nmi_pend is cleared.
REQ-023 An NMI edge arriving at or after FETCH_L SHALL stay pending and be serviced at the next sync.
REQ-024 An IRQ deasserting mid-sequence SHALL NOT abort the sequence; the captured source and vector are used.
REQ-025 Outside write states, wdata SHALL be 8'h00; outside IDLE/write states, rw SHALL be 1; in IDLE, a SHALL be 16'h0000.

Reset
REQ-026 While rst_n=0, the block SHALL hold state RST_L, busy=1, a=16'hFFFC, rw=1, sp_dec=0, pc_load=0, set_i=0, pc_new=16'h0000, wdata=8'h00, nmi_pend=0 and nmi_n previous sample=1.
REQ-027 After rst_n deasserts, the block SHALL run RST_L (a=FFFC)->RST_H (a=FFFD)->DONE->IDLE, with no pushes and no sp_dec.
REQ-028 Reset asserted mid-sequence SHALL abort immediately, with no further writes, and restart at REQ-026.

Configuration
REQ-029 Macro INT_SEQ_VECTORED_EN SHALL select the IRQ vector mode.
REQ-030 With INT_SEQ_VECTORED_EN defined, IRQ vec SHALL be IRQ_VEC_BASE+2*index; without it, every IRQ SHALL use 16'hFFFE.
REQ-031 NMI and reset vectors SHALL be unaffected by INT_SEQ_VECTORED_EN.

Verification
REQ-032 Reset check: release rst_n, d=8'h00 then 8'hC0 -> a=FFFC, then FFFD; pc_load with pc_new=16'hC000 on the 3rd cycle; busy falls on the 4th.
REQ-033 IRQ check: irq_n=4'b1110, i_flag=0, pc=16'h1234, p=8'h81, sp=8'hFD, sync=1 -> writes 12@01FD, 34@01FC, A1@01FB; 3 sp_dec pulses; vector read FFFE/FFFF (vectored build: FFE0/FFE1).
REQ-034 Masking and priority check: i_flag=1 with IRQ low -> no take; NMI edge plus irq_n=4'b1101 at the same sync -> FFFA fetch, then IRQ source 1 taken at the next sync (vectored build: FFE2).
REQ-035 Hijack and late-NMI check: NMI edge during PUSH_L of an IRQ -> FETCH_L reads FFFA; an edge during FETCH_H -> a second NMI sequence at the next sync.
REQ-036 Wrap and abort check: sp=8'h01 -> push addresses 0101, 0100, 01FF; rst_n pulled low in PUSH_L -> no write at 0100, and the reset sequence follows.
